phase_sign_gen: RTL and testbench

Parametrised N-phase current/voltage sign generator for bench and hardware-in-the-loop testing of the commutation datapath. It replaces fixed three-timer sign simulation with generic per-phase square waves. Phases are evenly spaced across one electrical period. Each phase has edge strobes, zero-crossing windows, pause, resynchronisation and phase-order reversal. Its `sign` output drives `CurrentSign` of `top_commutation`; the strobes and flags go to LEDs and the MCU.

---
 rtl/commutation_pkg.sv | 18 +
 rtl/phase_sign_cell.sv | 75 +++++++
 rtl/phase_sign_gen.sv | 50 +++++
 tb/tb_phase_sign_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/commutation_pkg.sv
// Shared constants and helpers for the commutation datapath and its
// test-signal generators.
package commutation_pkg;

  // 50 MHz / 120 Hz: one sign toggle per half period of a 60 Hz waveform.
  localparam int DEFAULT_HALF_PERIOD = 416667;

  // Offset of phase k of n within a period of p cycles.
  // Reverse order mirrors the forward offset about position 0.
  function automatic int phase_offset(input int k, input int n, input int p, input bit rev);
    int off;
    off = (k * p) / n;
    if (rev)
      return (p - off) % p;
    return off;
  endfunction

endpackage

// File: rtl/phase_sign_cell.sv
// One phase of the sign generator: position counter plus registered
// sign, zero-crossing and edge flags derived from the next position.
module phase_sign_cell #(
  parameter int HALF_PERIOD = 6,
  parameter int ZC_WINDOW   = 0,
  parameter int CNT_W       = 4,
  parameter int LOAD_FWD    = 0,
  parameter int LOAD_REV    = 0,
  parameter bit EXPORT_WRAP = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync,
  input  logic rev,
  output logic sign,
  output logic edge_stb,
  output logic zc,
  output logic wrap
);

  localparam int P  = 2 * HALF_PERIOD;
  // A zero window still needs legal compare bounds; the result is masked.
  localparam int ZW = (ZC_WINDOW > 0) ? ZC_WINDOW : 1;
  localparam bit ZC_EN = (ZC_WINDOW > 0);

  localparam logic [CNT_W-1:0] P_MAX     = CNT_W'(P - 1);
  localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(HALF_PERIOD);
  localparam logic [CNT_W-1:0] FWD_C     = CNT_W'(LOAD_FWD);
  localparam logic [CNT_W-1:0] REV_C     = CNT_W'(LOAD_REV);
  localparam logic [CNT_W-1:0] ZC_LO_END = CNT_W'(ZW);
  localparam logic [CNT_W-1:0] ZC_MID_LO = CNT_W'(HALF_PERIOD - ZW);
  localparam logic [CNT_W-1:0] ZC_MID_HI = CNT_W'(HALF_PERIOD + ZW);
  localparam logic [CNT_W-1:0] ZC_HI     = CNT_W'(P - ZW);

  function automatic logic in_zc(input logic [CNT_W-1:0] v);
    return ZC_EN && ((v < ZC_LO_END) ||
                     ((v >= ZC_MID_LO) && (v < ZC_MID_HI)) ||
                     (v >= ZC_HI));
  endfunction

  logic [CNT_W-1:0] pos;
  logic [CNT_W-1:0] pos_nxt;
  logic             step;
  logic             sign_nxt;

  always_comb begin
    pos_nxt = pos;
    step    = 1'b0;
    if (sync) begin
      pos_nxt = rev ? REV_C : FWD_C;
    end else if (en) begin
      step    = 1'b1;
      pos_nxt = (pos == P_MAX) ? '0 : pos + 1'b1;
    end
    sign_nxt = (pos_nxt >= HALF_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos      <= FWD_C;
      sign     <= (FWD_C >= HALF_C);
      zc       <= in_zc(FWD_C);
      edge_stb <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      pos      <= pos_nxt;
      sign     <= sign_nxt;
      zc       <= in_zc(pos_nxt);
      edge_stb <= step && (sign_nxt != sign);
      wrap     <= EXPORT_WRAP && step && (pos == P_MAX);
    end
  end

endmodule

// File: rtl/phase_sign_gen.sv
// N-phase square-wave sign generator with evenly spaced phases, used to
// stand in for measured current signs during bench and HIL testing.
module phase_sign_gen
  import commutation_pkg::*;
#(
  parameter int NPHASE      = 3,
  parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD,
  parameter int ZC_WINDOW   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic              rev,
  output logic [NPHASE-1:0] sign,
  output logic [NPHASE-1:0] edge_stb,
  output logic [NPHASE-1:0] zc,
  output logic              wrap_stb
);

  localparam int P     = 2 * HALF_PERIOD;
  localparam int CNT_W = $clog2(P);

  // Only phase 0 drives its wrap flag; the rest tie theirs low.
  logic [NPHASE-1:0] wrap_all;

  for (genvar k = 0; k < NPHASE; k++) begin : g_phase
    phase_sign_cell #(
      .HALF_PERIOD (HALF_PERIOD),
      .ZC_WINDOW   (ZC_WINDOW),
      .CNT_W       (CNT_W),
      .LOAD_FWD    (phase_offset(k, NPHASE, P, 1'b0)),
      .LOAD_REV    (phase_offset(k, NPHASE, P, 1'b1)),
      .EXPORT_WRAP (k == 0)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sync     (sync),
      .rev      (rev),
      .sign     (sign[k]),
      .edge_stb (edge_stb[k]),
      .zc       (zc[k]),
      .wrap     (wrap_all[k])
    );
  end

  assign wrap_stb = |wrap_all;

endmodule

// File: tb/tb_phase_sign_gen.sv
// Self-checking bench for phase_sign_gen against an arithmetic model of
// the phase positions (NPHASE=3, HALF_PERIOD=6, ZC_WINDOW=1).
module tb_phase_sign_gen;

  localparam int NP   = 3;
  localparam int HALF = 6;
  localparam int ZCW  = 1;
  localparam int P    = 2 * HALF;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sync;
  logic          rev;
  logic [NP-1:0] sign;
  logic [NP-1:0] edge_stb;
  logic [NP-1:0] zc;
  logic          wrap_stb;

  int checks = 0;
  int errors = 0;

  int            pos [NP];
  logic [NP-1:0] exp_edge;
  logic          exp_wrap;

  phase_sign_gen #(.NPHASE(NP), .HALF_PERIOD(HALF), .ZC_WINDOW(ZCW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .rev      (rev),
    .sign     (sign),
    .edge_stb (edge_stb),
    .zc       (zc),
    .wrap_stb (wrap_stb)
  );

  always #5 clk = ~clk;

  function automatic int off_of(int k, bit r);
    int o;
    o = (k * P) / NP;
    return r ? (P - o) % P : o;
  endfunction

  function automatic logic [NP-1:0] exp_sign();
    logic [NP-1:0] s;
    for (int k = 0; k < NP; k++) s[k] = (pos[k] >= HALF);
    return s;
  endfunction

  function automatic logic [NP-1:0] exp_zc();
    logic [NP-1:0] z;
    for (int k = 0; k < NP; k++)
      z[k] = (pos[k] < ZCW) || (pos[k] >= HALF - ZCW && pos[k] < HALF + ZCW) || (pos[k] >= P - ZCW);
    return z;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NP; k++) pos[k] = off_of(k, 1'b0);
    exp_edge = '0;
    exp_wrap = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic s, input logic r);
    logic [NP-1:0] old_sign;
    old_sign = exp_sign();
    exp_edge = '0;
    exp_wrap = 1'b0;
    if (s) begin
      for (int k = 0; k < NP; k++) pos[k] = off_of(k, r);
    end else if (e) begin
      exp_wrap = (pos[0] == P - 1);
      for (int k = 0; k < NP; k++) pos[k] = (pos[k] + 1) % P;
      exp_edge = exp_sign() ^ old_sign;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NP-1:0] es, ez;
    es = exp_sign();
    ez = exp_zc();
    checks++;
    assert (sign === es) else begin
      errors++;
      $error("FAIL %s sign observed=%b expected=%b", tag, sign, es);
    end
    checks++;
    assert (zc === ez) else begin
      errors++;
      $error("FAIL %s zc observed=%b expected=%b", tag, zc, ez);
    end
    checks++;
    assert (edge_stb === exp_edge) else begin
      errors++;
      $error("FAIL %s edge_stb observed=%b expected=%b", tag, edge_stb, exp_edge);
    end
    checks++;
    assert (wrap_stb === exp_wrap) else begin
      errors++;
      $error("FAIL %s wrap_stb observed=%b expected=%b", tag, wrap_stb, exp_wrap);
    end
  endtask

  task automatic step(input logic e, input logic s, input logic r, input string tag);
    en = e; sync = s; rev = r;
    @(posedge clk);
    #1;
    model_step(e, s, r);
    check_outputs(tag);
  endtask

  initial begin
    int toggles [NP];
    int wraps;
    logic [NP-1:0] prev_sign;

    rst = 1'b1; en = 1'b0; sync = 1'b0; rev = 1'b0;
    model_reset();
    #23 rst = 1'b0;
    @(posedge clk); #1;
    check_outputs("reset");
    checks++;
    assert (sign === 3'b100 && zc === 3'b001) else begin
      errors++;
      $error("FAIL reset_const sign/zc observed=%b/%b expected=100/001", sign, zc);
    end

    step(1'b1, 1'b0, 1'b0, "en1");
    step(1'b1, 1'b0, 1'b0, "en2");
    checks++;
    assert (edge_stb === 3'b010) else begin
      errors++;
      $error("FAIL en2_edge observed=%b expected=010", edge_stb);
    end
    step(1'b0, 1'b0, 1'b0, "edge_clear");

    wraps = 0;
    for (int k = 0; k < NP; k++) toggles[k] = 0;
    for (int i = 0; i < P; i++) begin
      prev_sign = sign;
      step(1'b1, 1'b0, 1'b0, "period");
      for (int k = 0; k < NP; k++) if (sign[k] !== prev_sign[k]) toggles[k]++;
      if (wrap_stb === 1'b1) wraps++;
    end
    checks++;
    assert (wraps == 1) else begin
      errors++;
      $error("FAIL period_wraps observed=%0d expected=1", wraps);
    end
    for (int k = 0; k < NP; k++) begin
      checks++;
      assert (toggles[k] == 2) else begin
        errors++;
        $error("FAIL period_toggles phase %0d observed=%0d expected=2", k, toggles[k]);
      end
    end

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, "hold");

    step(1'b1, 1'b0, 1'b0, "pre_sync");
    step(1'b1, 1'b0, 1'b0, "pre_sync");
    step(1'b1, 1'b0, 1'b0, "pre_sync");
    step(1'b1, 1'b1, 1'b1, "sync_rev");
    checks++;
    assert (sign === 3'b010 && edge_stb === 3'b000) else begin
      errors++;
      $error("FAIL sync_rev_const sign/edge observed=%b/%b expected=010/000", sign, edge_stb);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, "after_rev");

    en = 1'b1; sync = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk); #1;
    check_outputs("rst_held");
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
